// File: rtl/bypass_pkg.sv
// Shared defaults, latency classes and scoreboard entry type for the bypass scoreboard.
package bypass_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NREGS_DEF   = 32;
  localparam int NUM_RD_DEF  = 2;
  localparam int NUM_STG_DEF = 8;
  localparam int LAT_W_DEF   = 3;

  localparam logic [LAT_W_DEF-1:0] LAT_ALU  = 3'd0;
  localparam logic [LAT_W_DEF-1:0] LAT_LOAD = 3'd2;
  localparam logic [LAT_W_DEF-1:0] LAT_MUL  = 3'd5;

  // cnt is the number of cycles left until the result can be forwarded
  typedef struct packed {
    logic                 pend;
    logic [LAT_W_DEF-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/bypass_scoreboard_if.sv
// Decode/backend bundle for the bypass scoreboard; perf counters exist only with
// BYPASS_SCOREBOARD_PERF_EN defined.
interface bypass_scoreboard_if
  import bypass_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int AW      = $clog2(NREGS),
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter int NUM_STG = NUM_STG_DEF,
  parameter int LAT_W   = LAT_W_DEF
);
  logic                      hold_i;
  logic                      flush_i;
  logic                      iss_valid_i;
  logic                      iss_wr_en_i;
  logic [AW-1:0]             iss_wr_addr_i;
  logic [LAT_W-1:0]          iss_lat_i;
  logic [NUM_RD-1:0]         iss_rd_en_i;
  logic [NUM_RD*AW-1:0]      iss_rd_addr_i;
  logic [NUM_STG-1:0]        stg_valid_i;
  logic [NUM_STG*AW-1:0]     stg_addr_i;
  logic [NUM_STG*XLEN-1:0]   stg_data_i;
  logic [NUM_STG-1:0]        stg_ready_i;
  logic                      wb_en_i;
  logic [AW-1:0]             wb_addr_i;
  logic [NUM_RD-1:0]         byp_en_o;
  logic [NUM_RD*XLEN-1:0]    byp_data_o;
  logic                      stall_o;
`ifdef BYPASS_SCOREBOARD_PERF_EN
  logic [31:0]               perf_stall_raw_o;
  logic [31:0]               perf_stall_waw_o;
  logic [31:0]               perf_byp_o;
`endif

  modport master (
    output hold_i, flush_i, iss_valid_i, iss_wr_en_i, iss_wr_addr_i, iss_lat_i,
           iss_rd_en_i, iss_rd_addr_i, stg_valid_i, stg_addr_i, stg_data_i,
           stg_ready_i, wb_en_i, wb_addr_i,
`ifdef BYPASS_SCOREBOARD_PERF_EN
    input  perf_stall_raw_o, perf_stall_waw_o, perf_byp_o,
`endif
    input  byp_en_o, byp_data_o, stall_o
  );

  modport slave (
    input  hold_i, flush_i, iss_valid_i, iss_wr_en_i, iss_wr_addr_i, iss_lat_i,
           iss_rd_en_i, iss_rd_addr_i, stg_valid_i, stg_addr_i, stg_data_i,
           stg_ready_i, wb_en_i, wb_addr_i,
`ifdef BYPASS_SCOREBOARD_PERF_EN
    output perf_stall_raw_o, perf_stall_waw_o, perf_byp_o,
`endif
    output byp_en_o, byp_data_o, stall_o
  );

endinterface

// File: rtl/bypass_prio_mux.sv
// Priority match-and-select for one read port: lowest-index (youngest) stage wins,
// write-back (data from the oldest stage) is the fallback.
module bypass_prio_mux #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NUM_STG = 8
) (
  input  logic [AW-1:0]           addr,
  input  logic [NUM_STG-1:0]      stg_valid,
  input  logic [NUM_STG*AW-1:0]   stg_addr,
  input  logic [NUM_STG*XLEN-1:0] stg_data,
  input  logic [NUM_STG-1:0]      stg_ready,
  input  logic                    wb_en,
  input  logic [AW-1:0]           wb_addr,
  output logic                    hit,
  output logic                    ready,
  output logic [XLEN-1:0]         data
);

  logic [NUM_STG-1:0] stg_match;

  for (genvar gi = 0; gi < NUM_STG; gi++) begin : g_match
    assign stg_match[gi] = stg_valid[gi] && (stg_addr[gi*AW +: AW] == addr);
  end

  always_comb begin
    hit   = wb_en && (wb_addr == addr);
    ready = 1'b1;
    data  = hit ? stg_data[(NUM_STG-1)*XLEN +: XLEN] : '0;
    // Scan oldest to youngest so the youngest match is the last to overwrite
    for (int i = NUM_STG - 1; i >= 0; i--) begin
      if (stg_match[i]) begin
        hit   = 1'b1;
        ready = stg_ready[i];
        data  = stg_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// Latency-driven forwarding/hazard unit; BYPASS_SCOREBOARD_PERF_EN adds stall and
// bypass performance counters.
module bypass_scoreboard
  import bypass_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int AW      = $clog2(NREGS),
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter int NUM_STG = NUM_STG_DEF,
  parameter int LAT_W   = LAT_W_DEF
) (
  input logic                clk_i,
  input logic                rst_i,
  bypass_scoreboard_if.slave bus
);

  sb_entry_t sb_reg [NREGS];

  logic [NUM_RD-1:0]      port_stall;
  logic [NUM_RD-1:0]      port_byp;
  logic [NUM_RD*XLEN-1:0] port_data;
  logic                   raw_stall;
  logic                   waw_stall;
  logic                   stall_int;
  logic                   issue_fire;
  sb_entry_t              wr_ent;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
    logic [AW-1:0]   rd_addr;
    sb_entry_t       ent;
    logic            used;
    logic            busy;
    logic            hit;
    logic            ready;
    logic [XLEN-1:0] data;

    assign rd_addr = bus.iss_rd_addr_i[gi*AW +: AW];
    assign ent     = sb_reg[rd_addr];
    assign used    = bus.iss_rd_en_i[gi] && (rd_addr != '0);
    assign busy    = ent.pend && (ent.cnt != '0);

    bypass_prio_mux #(
      .XLEN    (XLEN),
      .AW      (AW),
      .NUM_STG (NUM_STG)
    ) u_mux (
      .addr      (rd_addr),
      .stg_valid (bus.stg_valid_i),
      .stg_addr  (bus.stg_addr_i),
      .stg_data  (bus.stg_data_i),
      .stg_ready (bus.stg_ready_i),
      .wb_en     (bus.wb_en_i),
      .wb_addr   (bus.wb_addr_i),
      .hit       (hit),
      .ready     (ready),
      .data      (data)
    );

    // A matching producer without valid data stalls even for non-pending operands
    assign port_stall[gi]              = used && (busy || (hit && !ready));
    assign port_byp[gi]                = used && !busy && hit && ready;
    assign port_data[gi*XLEN +: XLEN]  = port_byp[gi] ? data : '0;
  end

  assign wr_ent     = sb_reg[bus.iss_wr_addr_i];
  assign raw_stall  = |port_stall;
  assign waw_stall  = bus.iss_valid_i && bus.iss_wr_en_i && (bus.iss_wr_addr_i != '0) &&
                      wr_ent.pend && (bus.iss_lat_i < wr_ent.cnt);
  assign stall_int  = raw_stall || waw_stall;
  assign issue_fire = bus.iss_valid_i && bus.iss_wr_en_i && !stall_int &&
                      !bus.hold_i && !bus.flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      for (int r = 0; r < NREGS; r++) begin
        sb_reg[r] <= '0;
      end
    end else begin
      sb_reg[0] <= '0;
      for (int r = 1; r < NREGS; r++) begin
        if (issue_fire && (bus.iss_wr_addr_i == AW'(r))) begin
          sb_reg[r].pend <= 1'b1;
          sb_reg[r].cnt  <= bus.iss_lat_i;
        end else begin
          if (!bus.hold_i && (sb_reg[r].cnt != '0)) begin
            sb_reg[r].cnt <= sb_reg[r].cnt - 1'b1;
          end
          if (bus.wb_en_i && (bus.wb_addr_i == AW'(r)) && sb_reg[r].pend &&
              (sb_reg[r].cnt == '0)) begin
            sb_reg[r].pend <= 1'b0;
          end
        end
      end
    end
  end

  // Outputs are forced quiet for the whole reset cycle
  assign bus.stall_o    = !rst_i && stall_int;
  assign bus.byp_en_o   = rst_i ? '0 : port_byp;
  assign bus.byp_data_o = rst_i ? '0 : port_data;

`ifdef BYPASS_SCOREBOARD_PERF_EN
  logic [31:0] perf_raw_reg;
  logic [31:0] perf_waw_reg;
  logic [31:0] perf_byp_reg;
  logic [31:0] byp_count;

  always_comb begin
    byp_count = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      byp_count = byp_count + {31'b0, port_byp[p]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_raw_reg <= '0;
      perf_waw_reg <= '0;
      perf_byp_reg <= '0;
    end else if (!bus.hold_i) begin
      perf_raw_reg <= perf_raw_reg + {31'b0, raw_stall};
      perf_waw_reg <= perf_waw_reg + {31'b0, waw_stall && !raw_stall};
      perf_byp_reg <= perf_byp_reg + byp_count;
    end
  end

  assign bus.perf_stall_raw_o = perf_raw_reg;
  assign bus.perf_stall_waw_o = perf_waw_reg;
  assign bus.perf_byp_o       = perf_byp_reg;
`endif

endmodule
